seq_nibble_add_ctrl: RTL and testbench
======================================

SEQ_NIBBLE_ADD_CTRL -- requirements
Module: seq_nibble_add_ctrl

Interface
REQ-001 Parameter: WIDTH, 16, operand width in bits. It SHALL be a multiple of 4 and at least 4. NIB = WIDTH/4.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_valid  in  2  request valid, one bit per requester i = 0, 1.
REQ-006 req_ready  out  2  request accepted; at most one bit is high.
REQ-007 req_a0, req_b0, req_a1, req_b1  in  WIDTH each  operands for requester 0 and requester 1.
REQ-008 req_cin  in  2  carry-in, one bit per requester.
REQ-009 res_valid  out  1  result valid.
REQ-010 res_ready  in  1  result consumed.
REQ-011 res_sum  out  WIDTH  sum.
REQ-012 res_cout  out  1  final carry-out.
REQ-013 res_id  out  1  index of the requester that owns the result.
REQ-014 add_a, add_b  out  4  nibble operands driven to the external 4-bit ripple adder.
REQ-015 add_cin  out  1  carry-in driven to the external adder.
REQ-016 add_sum  in  4  sum returned from the external adder (combinational).
REQ-017 add_cout  in  1  carry-out returned from the external adder.

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN, DONE.
  - IDLE->RUN on a request handshake.
  - RUN->DONE after NIB RUN cycles.
  - DONE->IDLE on res_valid && res_ready.
REQ-019 req_ready[i] SHALL be high only in IDLE, and only when req_valid[i] is high and requester i is the arbitration winner; it is combinational from state and req_valid.
REQ-020 On the handshake edge the block SHALL register:
  - the winner's operands and carry-in;
  - res_id;
  - the nibble counter, cleared to 0.
REQ-021 In RUN cycle k (k = 0..NIB-1):
  - add_a = captured A[4k+3:4k];
  - add_b = captured B[4k+3:4k];
  - add_cin = carry register, which holds the captured cin at k = 0;
  - on the edge, add_sum SHALL be written to res_sum[4k+3:4k] and add_cout SHALL be written to the carry register.
REQ-022 On the last RUN edge (k = NIB-1), add_cout SHALL be loaded into res_cout and the state SHALL become DONE.
REQ-023 res_valid SHALL be high exactly in DONE. It first goes high NIB edges after the acceptance edge (4 for WIDTH = 16), and the block SHALL NOT add any further latency.
REQ-024 res_sum, res_cout and res_id SHALL hold stable while res_valid is high and res_ready is low (backpressure of unbounded length).
REQ-025 The block SHALL NOT accept a request in RUN or DONE. After the DONE handshake, a new request can be accepted on the next edge at the earliest.
REQ-026 Outside RUN, add_a, add_b and add_cin SHALL be driven to 0.
REQ-027 The nibble counter SHALL NOT wrap: it stops at NIB-1 and is cleared on acceptance.
REQ-028 For WIDTH = 4, RUN SHALL last exactly one cycle.
REQ-029 Requesters SHALL hold req_valid and operands stable until req_ready. The block samples operands only on the handshake edge, so later operand changes do not affect an operation in flight.
REQ-030 Arbitration when only one req_valid bit is high: that requester SHALL win. Arbitration when both are high: see REQ-034/REQ-035.

Reset
REQ-031 While rst is high on a clock edge, the block SHALL:
  - enter IDLE;
  - set res_valid = 0, res_sum = 0, res_cout = 0, res_id = 0;
  - clear the carry register, nibble counter and round-robin pointer to 0.
REQ-032 Reset asserted mid-RUN or in DONE SHALL abandon the operation with no result output. req_ready SHALL be 0 during the reset cycle.
REQ-033 The first edge after rst deasserts SHALL be able to accept a request.

Configuration
REQ-034 Macro SEQ_ADD_RR_EN defined: round-robin arbitration.
  - A last-grant pointer SHALL update on each handshake.
  - When both requesters are valid, the requester not granted last SHALL win.
  - After reset the pointer SHALL favour requester 0.
REQ-035 Macro SEQ_ADD_RR_EN undefined: fixed priority. Requester 0 SHALL always win when both are valid, and no pointer register SHALL exist.

Verification
REQ-036 Carry ripple: WIDTH = 16, req0 A = 0xFFFF, B = 0x0001, cin = 0 -> 4 edges later res_sum = 0x0000, res_cout = 1, res_id = 0; add_cin sequence 0,1,1,1.
REQ-037 Carry-in only: req1 A = 0x1234, B = 0x4321, cin = 1 -> res_sum = 0x5556, res_cout = 0, res_id = 1.
REQ-038 Arbitration: both valid continuously, three operations.
  - With SEQ_ADD_RR_EN: grant order 0,1,0.
  - Without SEQ_ADD_RR_EN: grant order 0,0,0.
REQ-039 Backpressure: res_ready held low 10 cycles in DONE -> res_valid and res_sum stable throughout, req_ready = 0; acceptance occurs no earlier than the edge after the DONE handshake.
REQ-040 Reset mid-operation: rst pulsed during RUN cycle k = 2 -> IDLE, no res_valid pulse, all outputs 0; the next request completes correctly.
REQ-041 Minimal width: WIDTH = 4, A = 0xF, B = 0xF, cin = 1 -> after 1 edge res_sum = 0xF, res_cout = 1.

Source files
------------

// File: rtl/seq_nibble_add_ctrl.sv
// Sequential WIDTH-bit adder that time-shares an external 4-bit ripple adder, one nibble per cycle.
// Two requesters; define SEQ_ADD_RR_EN for round-robin arbitration, otherwise requester 0 has fixed priority.
module seq_nibble_add_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [1:0]       req_cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout
);

  localparam int unsigned NIB   = WIDTH / 4;
  localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               id_q, id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         grant_c;
  logic               last_nib_c;

`ifdef SEQ_ADD_RR_EN
  // ptr_q = 1 means requester 1 wins the next contended request
  logic ptr_q, ptr_d;

  always_comb begin
    grant_c = 2'b00;
    case (req_valid)
      2'b01:   grant_c = 2'b01;
      2'b10:   grant_c = 2'b10;
      2'b11:   grant_c = ptr_q ? 2'b10 : 2'b01;
      default: grant_c = 2'b00;
    endcase
  end
`else
  always_comb begin
    grant_c = 2'b00;
    case (req_valid)
      2'b01:   grant_c = 2'b01;
      2'b10:   grant_c = 2'b10;
      2'b11:   grant_c = 2'b01;
      default: grant_c = 2'b00;
    endcase
  end
`endif

  assign last_nib_c = (cnt_q == CNT_W'(NIB - 1));

  // Next-state, datapath and handshake outputs
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    req_ready = 2'b00;
    res_valid = 1'b0;
    add_a     = 4'h0;
    add_b     = 4'h0;
    add_cin   = 1'b0;
`ifdef SEQ_ADD_RR_EN
    ptr_d     = ptr_q;
`endif

    case (state_q)
      IDLE: begin
        req_ready = grant_c;
        if (grant_c != 2'b00) begin
          state_d = RUN;
          id_d    = grant_c[1];
          a_d     = grant_c[1] ? req_a1 : req_a0;
          b_d     = grant_c[1] ? req_b1 : req_b0;
          carry_d = grant_c[1] ? req_cin[1] : req_cin[0];
          cnt_d   = '0;
`ifdef SEQ_ADD_RR_EN
          ptr_d   = ~grant_c[1];
`endif
        end
      end

      RUN: begin
        add_a   = 4'(a_q >> {cnt_q, 2'b00});
        add_b   = 4'(b_q >> {cnt_q, 2'b00});
        add_cin = carry_q;
        carry_d = add_cout;
        for (int unsigned i = 0; i < NIB; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            sum_d[4*i +: 4] = add_sum;
          end
        end
        if (last_nib_c) begin
          cout_d  = add_cout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // A reset edge wins over any handshake, so never advertise acceptance then
    if (rst) begin
      req_ready = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef SEQ_ADD_RR_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
`ifdef SEQ_ADD_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign res_sum  = sum_q;
  assign res_cout = cout_q;
  assign res_id   = id_q;

endmodule

// File: tb/tb_seq_nibble_add_ctrl.sv
// Scoreboard bench for seq_nibble_add_ctrl: directed corner cases, then randomized traffic against a cycle-count reference model.
module tb_seq_nibble_add_ctrl;

  localparam int unsigned W   = 16;
  localparam int unsigned NIB = W / 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    req_valid, req_ready, req_cin;
  logic [W-1:0]  req_a0, req_b0, req_a1, req_b1;
  logic          res_valid, res_ready, res_cout, res_id;
  logic [W-1:0]  res_sum;
  logic [3:0]    add_a, add_b, add_sum;
  logic          add_cin, add_cout;

  // Second instance at the minimum width
  logic [1:0]    v4, rdy4, cin4;
  logic [3:0]    a04, b04, a14, b14, sum4, add_a4, add_b4, add_sum4;
  logic          res_valid4, rr4, cout4, id4, add_cin4, add_cout4;

  // External 4-bit ripple adders
  assign {add_cout, add_sum}   = 5'(add_a) + 5'(add_b) + 5'(add_cin);
  assign {add_cout4, add_sum4} = 5'(add_a4) + 5'(add_b4) + 5'(add_cin4);

  seq_nibble_add_ctrl #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1), .req_cin(req_cin),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
  );

  seq_nibble_add_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(v4), .req_ready(rdy4),
    .req_a0(a04), .req_b0(b04), .req_a1(a14), .req_b1(b14), .req_cin(cin4),
    .res_valid(res_valid4), .res_ready(rr4), .res_sum(sum4), .res_cout(cout4), .res_id(id4),
    .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4), .add_sum(add_sum4), .add_cout(add_cout4)
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         id;
  } res_t;

  int   checks   = 0;
  int   failures = 0;
  res_t exp_q[$];
  res_t last_res;
  int   grants[$];
  logic [3:0] cin_hist = 4'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL timeout_%s t=%0t", name, $time);
  endtask

  // Reference model: an operation is outstanding for NIB edges, then waits for res_ready
  bit           m_busy = 0, m_done = 0, m_pref = 0, post_rst = 0;
  int           m_left = 0;
  int           m_k;
  logic [W-1:0] m_a, m_b;
  logic         m_cin;
  logic [1:0]   m_er;
  logic [31:0]  m_msk, m_lo;
  logic [W:0]   m_full;

  always @(negedge clk) begin
    if (post_rst) begin
      chk("post_reset_outputs", {res_valid, res_sum, res_cout, res_id}, '0);
      post_rst = 0;
    end
    m_er = 2'b00;
    if (!rst && !m_busy) begin
      if (req_valid == 2'b01)      m_er = 2'b01;
      else if (req_valid == 2'b10) m_er = 2'b10;
      else if (req_valid == 2'b11) begin
`ifdef SEQ_ADD_RR_EN
        m_er = m_pref ? 2'b10 : 2'b01;
`else
        m_er = 2'b01;
`endif
      end
    end
    chk("req_ready", req_ready, m_er);
    chk("res_valid", res_valid, m_done);
    if (m_busy && !m_done) begin
      m_k   = NIB - m_left;
      m_msk = (32'd1 << (4 * m_k)) - 32'd1;
      m_lo  = (32'(m_a) & m_msk) + (32'(m_b) & m_msk) + 32'(m_cin);
      chk("add_a", add_a, 4'((m_a >> (4 * m_k)) & 16'hF));
      chk("add_b", add_b, 4'((m_b >> (4 * m_k)) & 16'hF));
      chk("add_cin", add_cin, m_lo[4*m_k]);
      cin_hist = {cin_hist[2:0], add_cin};
    end else begin
      chk("adder_idle", {add_a, add_b, add_cin}, '0);
    end
    if (!rst && req_ready != 2'b00) grants.push_back(int'(req_ready[1]));

    if (rst) begin
      m_busy = 0; m_done = 0; m_pref = 0; post_rst = 1;
      exp_q.delete();
    end else if (m_done) begin
      if (res_ready) begin m_done = 0; m_busy = 0; end
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) m_done = 1;
    end else if (m_er != 2'b00) begin
      m_a    = m_er[1] ? req_a1 : req_a0;
      m_b    = m_er[1] ? req_b1 : req_b0;
      m_cin  = m_er[1] ? req_cin[1] : req_cin[0];
      m_full = (W+1)'(m_a) + (W+1)'(m_b) + (W+1)'(m_cin);
      exp_q.push_back({m_full[W-1:0], m_full[W], m_er[1]});
      m_busy = 1; m_left = NIB;
      m_pref = (m_er == 2'b01);
    end
  end

  // Monitor: every cycle a result is presented it must equal the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && res_valid) begin
      if (exp_q.size() == 0) begin
        timeout("unexpected_result");
      end else begin
        chk("res_sum", res_sum, exp_q[0].sum);
        chk("res_cout", res_cout, exp_q[0].cout);
        chk("res_id", res_id, exp_q[0].id);
        if (res_ready) begin
          last_res = {res_sum, res_cout, res_id};
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int i);
    bit ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (req_ready[i]) ok = 1;
    end
    if (!ok) timeout("req_ready");
    tick();
  endtask

  task automatic wait_result();
    bit ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (res_valid && res_ready) ok = 1;
    end
    if (!ok) timeout("result");
    tick();
  endtask

  task automatic rnd_op(output logic [W-1:0] v);
    v = ($urandom_range(0, 3) == 0) ? '1 : W'($urandom);
  endtask

  logic [W-1:0] held;
  logic [1:0]   acc;
  logic [W-1:0] tmp;
  int           g0;
  bit           ok;

  initial begin
    rst = 1'b1; req_valid = 2'b00; req_cin = 2'b00; res_ready = 1'b1;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    v4 = 2'b00; cin4 = 2'b00; a04 = 4'h0; b04 = 4'h0; a14 = 4'h0; b14 = 4'h0; rr4 = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Minimal width: a single RUN cycle
    v4 = 2'b01; a04 = 4'hF; b04 = 4'hF; cin4 = 2'b01;
    @(negedge clk); chk("w4_req_ready", rdy4, 2'b01);
    tick(); v4 = 2'b00;
    @(negedge clk); chk("w4_run_valid", res_valid4, 1'b0);
    chk("w4_run_adder", {add_a4, add_b4, add_cin4}, {4'hF, 4'hF, 1'b1});
    tick();
    @(negedge clk); chk("w4_done", {res_valid4, sum4, cout4, id4}, {1'b1, 4'hF, 1'b1, 1'b0});
    tick();
    @(negedge clk); chk("w4_idle", res_valid4, 1'b0);

    // Carry ripple through all nibbles
    req_a0 = 16'hFFFF; req_b0 = 16'h0001; req_cin = 2'b00; req_valid = 2'b01;
    wait_ready(0); req_valid = 2'b00;
    wait_result();
    chk("ripple_result", last_res, {16'h0000, 1'b1, 1'b0});
    chk("ripple_cin_seq", cin_hist, 4'b0111);

    // Carry-in only, requester 1
    req_a1 = 16'h1234; req_b1 = 16'h4321; req_cin = 2'b10; req_valid = 2'b10;
    wait_ready(1); req_valid = 2'b00;
    wait_result();
    chk("cin_result", last_res, {16'h5556, 1'b0, 1'b1});

    // Contention from a fresh reset
    rst = 1'b1; tick(); rst = 1'b0;
    rnd_op(req_a0); rnd_op(req_b0); rnd_op(req_a1); rnd_op(req_b1);
    req_valid = 2'b11;
    g0 = grants.size();
    ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      tick();
      if (grants.size() >= g0 + 3) ok = 1;
    end
    req_valid = 2'b00;
    if (!ok) timeout("arbitration");
    else begin
      chk("grant0", grants[g0], 0);
`ifdef SEQ_ADD_RR_EN
      chk("grant1", grants[g0+1], 1);
`else
      chk("grant1", grants[g0+1], 0);
`endif
      chk("grant2", grants[g0+2], 0);
    end
    repeat (10) tick();

    // Backpressure with a competing request waiting
    rnd_op(req_a0); rnd_op(req_b0); rnd_op(req_a1); rnd_op(req_b1);
    req_valid = 2'b01; res_ready = 1'b0;
    wait_ready(0);
    req_valid = 2'b10;
    ok = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (res_valid) ok = 1; else tick();
    end
    if (!ok) timeout("bp_valid");
    held = res_sum;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("bp_hold", {res_valid, res_sum, req_ready}, {1'b1, held, 2'b00});
    end
    tick(); res_ready = 1'b1;
    @(negedge clk); chk("bp_release_ready", req_ready, 2'b00);
    tick();
    @(negedge clk); chk("bp_next_accept", req_ready, 2'b10);
    tick(); req_valid = 2'b00;
    wait_result();
    repeat (5) tick();

    // Reset during RUN nibble 2
    rnd_op(req_a0); rnd_op(req_b0); req_a0[11:8] = 4'hA; req_valid = 2'b01;
    wait_ready(0); req_valid = 2'b00;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    chk("abort_outputs", {res_valid, res_sum, res_cout, res_id, add_a, add_b, add_cin}, '0);
    rnd_op(req_a1); rnd_op(req_b1); req_cin = 2'b10; req_valid = 2'b10;
    wait_ready(1); req_valid = 2'b00;
    wait_result();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = req_ready;
      tick();
      rst = ($urandom_range(0, 149) == 0);
      res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] || acc[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_cin[i]   = 1'($urandom_range(0, 1));
          rnd_op(tmp); if (i == 0) req_a0 = tmp; else req_a1 = tmp;
          rnd_op(tmp); if (i == 0) req_b0 = tmp; else req_b1 = tmp;
        end
      end
    end
    req_valid = 2'b00; rst = 1'b0; res_ready = 1'b1;
    repeat (20) tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
